// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, data port and external memory port
// of the DLX memory arbiter.
//   master modport : arbiter view (takes requests, drives the memory bus)
//   slave  modport : environment view (requesters and memory model)
// Fetch   : inst_rd_en, inst_addr, flush -> inst_data, inst_ready
// Data    : data_rd_en, data_wr_en, data_addr, data_wr_data
//           -> data_rd_data, data_ready, mem_stall
// Memory  : mem_req, mem_we, mem_addr, mem_wdata <- mem_rdata, mem_ack
// Status  : bus_error
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  inst_rd_en;
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic [DATA_WIDTH-1:0] inst_data;
  logic                  inst_ready;
  logic                  flush;

  logic                  data_rd_en;
  logic                  data_wr_en;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [DATA_WIDTH-1:0] data_wr_data;
  logic [DATA_WIDTH-1:0] data_rd_data;
  logic                  data_ready;
  logic                  mem_stall;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  logic                  bus_error;

  modport master (
    input  inst_rd_en, inst_addr, flush,
    input  data_rd_en, data_wr_en, data_addr, data_wr_data,
    input  mem_rdata, mem_ack,
    output inst_data, inst_ready,
    output data_rd_data, data_ready, mem_stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output bus_error
  );

  modport slave (
    output inst_rd_en, inst_addr, flush,
    output data_rd_en, data_wr_en, data_addr, data_wr_data,
    output mem_rdata, mem_ack,
    input  inst_data, inst_ready,
    input  data_rd_data, data_ready, mem_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  bus_error
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory port between the instruction-fetch
// stage and the data (MEM) stage. Data accesses win over fetches; a granted
// request is latched and held on the memory bus until mem_ack or timeout,
// then a one-cycle ready pulse is returned to the requester.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mem_arbiter_if.master (fetch, data and memory signal groups)
// Parameters:
//   ADDR_WIDTH, DATA_WIDTH : bus widths (must match the interface)
//   TIMEOUT                : grant cycles without mem_ack before abort (2..65535)
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2
  } state_e;

  // Counter starts at 0 in the first mem_req cycle, so reaching TIMEOUT-1
  // means mem_req has been high for TIMEOUT cycles.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  discard_q, discard_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] inst_data_q, inst_data_d;
  logic                  inst_ready_q, inst_ready_d;
  logic [DATA_WIDTH-1:0] data_rd_data_q, data_rd_data_d;
  logic                  data_ready_q, data_ready_d;
  logic                  bus_error_q, bus_error_d;
  logic                  done, abort, drop_fetch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      discard_q      <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      inst_data_q    <= '0;
      inst_ready_q   <= 1'b0;
      data_rd_data_q <= '0;
      data_ready_q   <= 1'b0;
      bus_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      discard_q      <= discard_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      inst_data_q    <= inst_data_d;
      inst_ready_q   <= inst_ready_d;
      data_rd_data_q <= data_rd_data_d;
      data_ready_q   <= data_ready_d;
      bus_error_q    <= bus_error_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    discard_d      = discard_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    inst_data_d    = inst_data_q;
    inst_ready_d   = 1'b0;
    data_rd_data_d = data_rd_data_q;
    data_ready_d   = 1'b0;
    bus_error_d    = 1'b0;
    done           = 1'b0;
    abort          = 1'b0;
    // A flush on the completing edge itself must also suppress the fetch.
    drop_fetch     = discard_q | bus.flush;

    case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (bus.data_rd_en || bus.data_wr_en) begin
          state_d     = GRANT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.data_wr_en;
          mem_addr_d  = bus.data_addr;
          mem_wdata_d = bus.data_wr_data;
          cnt_d       = '0;
        end else if (bus.inst_rd_en) begin
          state_d    = GRANT_I;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.inst_addr;
          cnt_d      = '0;
        end
      end

      GRANT_D, GRANT_I: begin
        // Ack on the timeout edge counts as a normal completion.
        if (bus.mem_ack) begin
          done = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end

        if (done || abort) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          discard_d   = 1'b0;
          bus_error_d = abort;
          if (state_q == GRANT_D) begin
            data_ready_d = 1'b1;
            // Stores leave the load result register untouched.
            if (!mem_we_q) begin
              data_rd_data_d = done ? bus.mem_rdata : '0;
            end
          end else if (!drop_fetch) begin
            inst_ready_d = 1'b1;
            inst_data_d  = done ? bus.mem_rdata : '0;
          end
        end else if (state_q == GRANT_I) begin
          discard_d = drop_fetch;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.inst_data    = inst_data_q;
  assign bus.inst_ready   = inst_ready_q;
  assign bus.data_rd_data = data_rd_data_q;
  assign bus.data_ready   = data_ready_q;
  assign bus.bus_error    = bus_error_q;
  // Stall releases in the data_ready cycle so the MEM stage can advance.
  assign bus.mem_stall    = (bus.data_rd_en | bus.data_wr_en) & ~data_ready_q;

endmodule
